instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 27 ++
 rtl/instr_fetch_if.sv | 40 ++++
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared core definitions for the instruction fetch stage: PC width, reset vector,
// increment constant, fetch FSM states and the captured instruction payload.
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } inst_t;

  // Word-aligned instruction addresses only.
  function automatic logic pc_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: branch redirect, instruction memory request/response and
// the decoded-instruction handoff. master = fetch unit, slave = its environment.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  logic            fault;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_ready,
    output imem_req_valid, imem_req_addr,
    output inst_valid, inst_data, inst_pc,
    output fault
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_ready,
    input  imem_req_valid, imem_req_addr,
    input  inst_valid, inst_data, inst_pc,
    input  fault
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, +4 incrementer and a FETCH/WAIT/HOLD/FAULT FSM
// keeping at most one memory request in flight, with redirect and misalignment handling.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_if.master      bus
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            drop;
  logic            req_valid;
  logic            inst_valid;
  inst_t           inst;
  logic            fault;

  logic            redirect;
  logic            redirect_ok;
  logic            rsp_valid;
  logic            req_fire;
  logic            pending;
  logic            pending_next;

  assign redirect    = bus.redirect_valid;
  assign redirect_ok = pc_aligned(bus.redirect_pc);
  assign rsp_valid   = bus.imem_rsp_valid;
  assign req_fire    = req_valid & bus.imem_req_ready;

  // A response is owed by memory if we are waiting on it or a stale one is still due;
  // after this edge it is owed if newly accepted or not yet returned.
  assign pending      = (state == WAIT) | drop;
  assign pending_next = req_fire | (pending & ~rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      req_valid  <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      fault      <= 1'b0;
    end else if (redirect) begin
      // Redirect overrides everything; any still-owed response becomes stale.
      pc         <= bus.redirect_pc;
      inst_valid <= 1'b0;
      drop       <= pending_next;
      if (!redirect_ok) begin
        state     <= FAULT;
        fault     <= 1'b1;
        req_valid <= 1'b0;
      end else begin
        fault <= 1'b0;
        if (pending_next && (state != FAULT)) begin
          state     <= WAIT;
          req_valid <= 1'b0;
        end else begin
          // Leaving FAULT with a stale response still owed: hold the request off until it lands.
          state     <= FETCH;
          req_valid <= ~pending_next;
        end
      end
    end else begin
      case (state)
        FETCH: begin
          if (drop) begin
            if (rsp_valid) begin
              drop      <= 1'b0;
              req_valid <= 1'b1;
            end
          end else if (req_fire) begin
            state     <= WAIT;
            req_valid <= 1'b0;
          end else begin
            req_valid <= 1'b1;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            if (drop) begin
              drop      <= 1'b0;
              state     <= FETCH;
              req_valid <= 1'b1;
            end else begin
              inst       <= '{data: bus.imem_rsp_data, pc: pc};
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.inst_ready) begin
            pc         <= pc + PC_INC;
            inst_valid <= 1'b0;
            state      <= FETCH;
            req_valid  <= 1'b1;
          end
        end
        FAULT: begin
          if (rsp_valid) begin
            drop <= 1'b0;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst_data      = inst.data;
  assign bus.inst_pc        = inst.pc;
  assign bus.fault          = fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run
// scored against an architectural PC-stream model and a latency-variable memory model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory model state
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_min;
  int          lat_max;
  int          ready_pct;
  logic [31:0] acc_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B9;
    return h ^ 32'h5A5A_0F0F;
  endfunction

  // One clock of memory behaviour, called at a negedge; returns at the next negedge.
  task automatic cyc();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(mem_addr);
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    bus.imem_req_ready = ($urandom_range(99) < ready_pct);
    if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
      checks++;
      if (mem_busy) begin
        errors++;
        $display("FAIL one_outstanding: request %h accepted while %h still in flight", bus.imem_req_addr, mem_addr);
      end
      mem_busy = 1'b1;
      mem_cnt  = int'($urandom_range(lat_max, lat_min));
      mem_addr = bus.imem_req_addr;
      acc_q.push_back(mem_addr);
    end
    @(negedge clk);
  endtask

  task automatic wait_inst(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (bus.inst_valid) begin
        got = 1'b1;
        return;
      end
      cyc();
    end
    got = bus.inst_valid;
  endtask

  task automatic wait_accept(input int max, output bit got, output logic [31:0] addr);
    int n0;
    n0   = acc_q.size();
    got  = 1'b0;
    addr = '0;
    for (int i = 0; i < max && !got; i++) begin
      cyc();
      if (acc_q.size() > n0) begin
        got  = 1'b1;
        addr = acc_q[n0];
      end
    end
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    mem_busy = 1'b0;
    mem_cnt  = 0;
    acc_q.delete();
    ready_pct = 100;
    lat_min   = 0;
    lat_max   = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    cyc();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit got;
    do_reset();
    wait_inst(20, got);
    checks++;
    if (!got) begin errors++; $display("FAIL reset_setup: no instruction before reset (timeout)"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    checks++;
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
    checks++;
    if (bus.inst_data !== 32'h0) begin errors++; $display("FAIL reset_inst_data: got %h want 0", bus.inst_data); end
    checks++;
    if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 0", bus.inst_pc); end
    checks++;
    if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
    mem_busy = 1'b0;
    acc_q.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_req: got %b want 0", bus.imem_req_valid); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_release_req: got %b want 0", bus.imem_req_valid); end
    @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_req: valid %b addr %h want 1 / 00000000", bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  task automatic test_sequential();
    bit got;
    logic [31:0] want;
    do_reset();
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      want = 32'(i * 4);
      wait_inst(20, got);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL seq_timeout: instruction %0d never valid", i);
      end else begin
        checks++;
        if (bus.inst_pc !== want) begin errors++; $display("FAIL seq_pc: got %h want %h", bus.inst_pc, want); end
        checks++;
        if (bus.inst_data !== mem_word(want)) begin errors++; $display("FAIL seq_data: got %h want %h", bus.inst_data, mem_word(want)); end
      end
      cyc();
    end
    checks++;
    if (acc_q.size() < 3 || acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4 || acc_q[2] !== 32'h8) begin
      errors++;
      $display("FAIL seq_addrs: %0d requests seen, want 0,4,8 in order", acc_q.size());
    end
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    bit got;
    logic [31:0] a;
    do_reset();
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_inst(20, got);
      cyc();
    end
    lat_min = 3;
    lat_max = 3;
    wait_accept(20, got, a);
    checks++;
    if (!got || a !== 32'h8) begin errors++; $display("FAIL rw_pre: accepted %h (got=%b) want 00000008", a, got); end
    redirect_to(32'h100);
    lat_min = 0;
    lat_max = 0;
    wait_accept(20, got, a);
    checks++;
    if (!got || a !== 32'h100) begin errors++; $display("FAIL rw_next_req: got %h want 00000100", a); end
    wait_inst(20, got);
    checks++;
    if (!got || bus.inst_pc !== 32'h100 || bus.inst_data !== mem_word(32'h100)) begin
      errors++;
      $display("FAIL rw_deliver: pc %h data %h want 00000100 / %h", bus.inst_pc, bus.inst_data, mem_word(32'h100));
    end
    cyc();
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    bit got;
    logic [31:0] spc, sdata, a;
    int n;
    do_reset();
    wait_inst(20, got);
    spc   = bus.inst_pc;
    sdata = bus.inst_data;
    n     = acc_q.size();
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== spc || bus.inst_data !== sdata || bus.imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_stable: v %b pc %h data %h req %b want 1 %h %h 0", bus.inst_valid, bus.inst_pc, bus.inst_data, bus.imem_req_valid, spc, sdata);
      end
    end
    checks++;
    if (acc_q.size() != n) begin errors++; $display("FAIL stall_no_req: %0d requests during stall want 0", acc_q.size() - n); end
    bus.inst_ready = 1'b1;
    cyc();
    bus.inst_ready = 1'b0;
    wait_accept(20, got, a);
    checks++;
    if (!got || a !== spc + 32'd4) begin errors++; $display("FAIL stall_next: got %h want %h", a, spc + 32'd4); end
  endtask

  task automatic test_fault();
    bit got;
    logic [31:0] a;
    int n;
    do_reset();
    bus.inst_ready = 1'b1;
    wait_inst(20, got);
    redirect_to(32'h102);
    checks++;
    if (bus.fault !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_enter: fault %b req %b want 1 0", bus.fault, bus.imem_req_valid);
    end
    n = acc_q.size();
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (bus.fault !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL fault_hold: fault %b req %b inst %b want 1 0 0", bus.fault, bus.imem_req_valid, bus.inst_valid);
      end
    end
    checks++;
    if (acc_q.size() != n) begin errors++; $display("FAIL fault_no_req: %0d requests in FAULT want 0", acc_q.size() - n); end
    redirect_to(32'h200);
    checks++;
    if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_exit: fault %b want 0", bus.fault); end
    wait_accept(20, got, a);
    checks++;
    if (!got || a !== 32'h200) begin errors++; $display("FAIL fault_next_req: got %h want 00000200", a); end
    wait_inst(20, got);
    checks++;
    if (!got || bus.inst_pc !== 32'h200 || bus.inst_data !== mem_word(32'h200)) begin
      errors++;
      $display("FAIL fault_deliver: pc %h data %h want 00000200", bus.inst_pc, bus.inst_data);
    end
    // Misaligned redirect with a response in flight; it must be swallowed in FAULT.
    lat_min = 2;
    lat_max = 2;
    cyc();
    wait_accept(20, got, a);
    redirect_to(32'h303);
    repeat (4) cyc();
    redirect_to(32'h300);
    lat_min = 0;
    lat_max = 0;
    wait_inst(20, got);
    checks++;
    if (!got || bus.inst_pc !== 32'h300 || bus.inst_data !== mem_word(32'h300)) begin
      errors++;
      $display("FAIL fault_swallow: pc %h data %h want 00000300 / %h", bus.inst_pc, bus.inst_data, mem_word(32'h300));
    end
    // Leave FAULT before the stale response has come back.
    lat_min = 5;
    lat_max = 5;
    cyc();
    wait_accept(20, got, a);
    redirect_to(32'h503);
    redirect_to(32'h400);
    checks++;
    if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_early_exit: fault %b want 0", bus.fault); end
    lat_min = 0;
    lat_max = 0;
    wait_inst(30, got);
    checks++;
    if (!got || bus.inst_pc !== 32'h400 || bus.inst_data !== mem_word(32'h400)) begin
      errors++;
      $display("FAIL fault_carry_drop: pc %h data %h want 00000400 / %h", bus.inst_pc, bus.inst_data, mem_word(32'h400));
    end
    cyc();
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit got;
    logic [31:0] a;
    do_reset();
    redirect_to(32'hFFFF_FFFC);
    bus.inst_ready = 1'b1;
    wait_inst(20, got);
    checks++;
    if (!got || bus.inst_pc !== 32'hFFFF_FFFC || bus.inst_data !== mem_word(32'hFFFF_FFFC)) begin
      errors++;
      $display("FAIL wrap_top: pc %h data %h want fffffffc", bus.inst_pc, bus.inst_data);
    end
    wait_accept(20, got, a);
    checks++;
    if (!got || a !== 32'h0) begin errors++; $display("FAIL wrap_next_req: got %h want 00000000", a); end
    wait_inst(20, got);
    checks++;
    if (!got || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL wrap_deliver: pc %h want 00000000", bus.inst_pc); end
    cyc();
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_redirect_handshake();
    bit got;
    logic [31:0] a;
    do_reset();
    redirect_to(32'h10);
    wait_inst(20, got);
    checks++;
    if (!got || bus.inst_pc !== 32'h10) begin errors++; $display("FAIL rh_setup: pc %h want 00000010", bus.inst_pc); end
    bus.inst_ready = 1'b1;
    redirect_to(32'h40);
    bus.inst_ready = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rh_clear: inst_valid %b want 0", bus.inst_valid); end
    wait_accept(20, got, a);
    checks++;
    if (!got || a !== 32'h40) begin errors++; $display("FAIL rh_next_req: got %h want 00000040", a); end
    wait_inst(20, got);
    checks++;
    if (!got || bus.inst_pc !== 32'h40 || bus.inst_data !== mem_word(32'h40)) begin
      errors++;
      $display("FAIL rh_deliver: pc %h data %h want 00000040", bus.inst_pc, bus.inst_data);
    end
  endtask

  // Random traffic: delivered stream must follow pc, pc+4, ... restarting at each redirect target.
  task automatic test_random();
    logic [31:0] exp_pc, exp_before, tgt, pv_addr, pv_ipc, pv_idata;
    bit pv_req, pv_inst, pv_iready, pv_redir, redir;
    int delivered, n;
    do_reset();
    ready_pct = 70;
    lat_min   = 0;
    lat_max   = 3;
    exp_pc    = 32'h0;
    delivered = 0;
    pv_req = 1'b0; pv_inst = 1'b0; pv_iready = 1'b0; pv_redir = 1'b0;
    pv_addr = '0; pv_ipc = '0; pv_idata = '0;
    for (int c = 0; c < 800; c++) begin
      if (pv_req && !bus.imem_req_ready && !pv_redir) begin
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== pv_addr) begin
          errors++;
          $display("FAIL rnd_req_hold: valid %b addr %h want 1 %h", bus.imem_req_valid, bus.imem_req_addr, pv_addr);
        end
      end
      if (pv_inst && !pv_iready && !pv_redir) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== pv_ipc || bus.inst_data !== pv_idata) begin
          errors++;
          $display("FAIL rnd_inst_hold: v %b pc %h data %h want 1 %h %h", bus.inst_valid, bus.inst_pc, bus.inst_data, pv_ipc, pv_idata);
        end
      end
      bus.inst_ready = ($urandom_range(99) < 70);
      redir = ($urandom_range(15) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0;
      bus.redirect_valid = redir;
      bus.redirect_pc    = tgt;
      exp_before = exp_pc;
      if (bus.inst_valid && bus.inst_ready) begin
        checks++;
        if (bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL rnd_deliver: pc %h data %h want %h %h", bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (redir) exp_pc = tgt;
      pv_req    = bus.imem_req_valid;
      pv_addr   = bus.imem_req_addr;
      pv_inst   = bus.inst_valid;
      pv_iready = bus.inst_ready;
      pv_ipc    = bus.inst_pc;
      pv_idata  = bus.inst_data;
      pv_redir  = redir;
      n = acc_q.size();
      cyc();
      if (acc_q.size() > n) begin
        checks++;
        if (acc_q[n] !== exp_before) begin
          errors++;
          $display("FAIL rnd_req_addr: got %h want %h", acc_q[n], exp_before);
        end
      end
    end
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    checks++;
    if (delivered < 30) begin errors++; $display("FAIL rnd_progress: %0d instructions delivered want >= 30", delivered); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    test_reset();
    test_sequential();
    test_redirect_wait();
    test_hold_stall();
    test_fault();
    test_wrap();
    test_redirect_handshake();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
